// File: rtl/iterative_alu.sv
// Execute-stage ALU. Logic, arithmetic and compare ops finish in one cycle.
// Shifts run through a bit-serial shifter that moves one bit position per cycle.
// A valid/ready handshake on each side lets pipeline control stall execute
// while a shift is in progress.
module iterative_alu #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALUop,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Out
);

  // ALU_* operation encodings, matching the ALU decoder
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SHAMT_W-1:0]  cnt;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   out_q;
  logic [3:0]          op_q;
  logic [SHAMT_W-1:0]  shamt_in;
  logic                shift_last;
  logic [DATA_W-1:0]   work_step;

  // True for the three ops that go through the serial shifter
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Single-cycle result; unknown opcodes yield zero
  function automatic logic [DATA_W-1:0] alu_single(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [DATA_W-1:0]        r;
    a_s = a;
    b_s = b;
    case (op)
      ALU_ADDU: r = a + b;
      ALU_SUBU: r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_LUI:  r = {b[15:0], {(DATA_W-16){1'b0}}};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // One bit position of shift; SRA replicates the sign bit
  function automatic logic [DATA_W-1:0] shift_step(input logic [3:0] op,
                                                   input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    case (op)
      ALU_SLL: r = {v[DATA_W-2:0], 1'b0};
      ALU_SRL: r = {1'b0, v[DATA_W-1:1]};
      default: r = {v[DATA_W-1], v[DATA_W-1:1]};
    endcase
    return r;
  endfunction

  assign shamt_in   = A[SHAMT_W-1:0];
  assign shift_last = (cnt == SHAMT_W'(1));
  assign work_step  = shift_step(op_q, work);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign Out        = out_q;

  // Next-state logic: zero-amount shifts bypass SHIFT, DONE waits for out_ready
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_shift(ALUop) && (shamt_in != '0)) state_next = SHIFT;
          else                                     state_next = DONE;
        end
      end
      SHIFT:   if (shift_last) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: capture operands on accept, step the shifter, latch the result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= ALUop;
            work <= B;
            cnt  <= shamt_in;
            if (is_shift(ALUop)) begin
              if (shamt_in == '0) out_q <= B;
            end else begin
              out_q <= alu_single(ALUop, A, B);
            end
          end
        end
        SHIFT: begin
          work <= work_step;
          cnt  <= cnt - SHAMT_W'(1);
          if (shift_last) out_q <= work_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: single-cycle ops, serial shifts,
// output backpressure and reset in the middle of a shift.
module tb_iterative_alu;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;

  int n_checks;
  int n_fail;

  iterative_alu #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for a single edge; returns #1 after the accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUop    = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 32'hDEADBEEF;
    B        = 32'hDEADBEEF;
    ALUop    = ALU_ADDU;
  endtask

  // Count edges from accept (inclusive) until out_valid, noting any in_ready
  task automatic wait_result(output int lat, output logic saw_ready);
    lat       = 1;
    saw_ready = in_ready;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && in_ready) saw_ready = 1'b1;
    end
  endtask

  // Hand the result to the consumer for one edge
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (Out !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h want 00000000", Out); end
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops  [9] = '{ALU_ADDU, ALU_SUBU, ALU_AND, ALU_NOR, ALU_SLT, ALU_SLTU,
                              ALU_LUI, ALU_OR, 4'd15};
    logic [31:0] as   [9] = '{32'hFFFFFFFF, 32'h5, 32'hF0F0F0F0, 32'h0000FFFF, 32'hFFFFFFFE,
                              32'hFFFFFFFE, 32'h12345678, 32'h0F, 32'h1234};
    logic [31:0] bs   [9] = '{32'h2, 32'h7, 32'hFFFF0000, 32'h00FF0000, 32'h1,
                              32'h1, 32'hFFFFABCD, 32'hF0, 32'h5678};
    logic [31:0] exps [9] = '{32'h1, 32'hFFFFFFFE, 32'hF0F00000, 32'hFF000000, 32'h1,
                              32'h0, 32'hABCD0000, 32'hFF, 32'h0};
    int   lat;
    logic saw_ready;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready op=%0d got %b want 0", ops[i], in_ready); end
      wait_result(lat, saw_ready);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL single_latency op=%0d got %0d want 1", ops[i], lat); end
      n_checks++;
      if (Out !== exps[i]) begin n_fail++; $display("FAIL single_out op=%0d got %h want %h", ops[i], Out, exps[i]); end
      consume();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ops  [5] = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLL, ALU_SRA};
    logic [31:0] as   [5] = '{32'h24, 32'h24, 32'h0, 32'h1F, 32'hFFFFFFE1};
    logic [31:0] bs   [5] = '{32'h80000F00, 32'h80000F00, 32'h1234, 32'h1, 32'h80000000};
    logic [31:0] exps [5] = '{32'hF80000F0, 32'h080000F0, 32'h1234, 32'h80000000, 32'hC0000000};
    int          lats [5] = '{5, 5, 1, 32, 2};
    int   lat;
    logic saw_ready;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_result(lat, saw_ready);
      n_checks++;
      if (lat !== lats[i]) begin n_fail++; $display("FAIL shift_latency case=%0d got %0d want %0d", i, lat, lats[i]); end
      n_checks++;
      if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL shift_in_ready case=%0d got %b want 0", i, saw_ready); end
      n_checks++;
      if (Out !== exps[i]) begin n_fail++; $display("FAIL shift_out case=%0d got %h want %h", i, Out, exps[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic saw_ready;
    issue(ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000);
    wait_result(lat, saw_ready);
    for (int c = 0; c < 10; c++) begin
      // Poke the input side; the held result must not move
      in_valid = c[0];
      ALUop    = ALU_ADDU;
      A        = 32'h11111111;
      B        = 32'h22222222;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Out !== 32'h0F0FF0F0) begin
        n_fail++;
        $display("FAIL hold cycle=%0d got v=%b r=%b out=%h want v=1 r=0 out=0F0FF0F0",
                 c, out_valid, in_ready, Out);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    consume();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    issue(ALU_ADDU, 32'h10, 32'h20);
    n_checks++;
    if (out_valid !== 1'b1 || Out !== 32'h30) begin
      n_fail++;
      $display("FAIL back_to_back got v=%b out=%h want v=1 out=00000030", out_valid, Out);
    end
    consume();
  endtask

  task automatic test_reset_midshift();
    int   lat;
    logic saw_ready;
    issue(ALU_SLL, 32'd20, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (Out !== 32'h0) begin n_fail++; $display("FAIL midreset_out got %h want 00000000", Out); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    issue(ALU_OR, 32'h0F, 32'hF0);
    wait_result(lat, saw_ready);
    n_checks++;
    if (lat !== 1 || Out !== 32'hFF) begin
      n_fail++;
      $display("FAIL after_reset_or got lat=%0d out=%h want lat=1 out=000000FF", lat, Out);
    end
    consume();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALUop     = 4'd0;
    A         = 32'h0;
    B         = 32'h0;
    test_reset();
    test_single_cycle();
    test_shift();
    test_backpressure();
    test_reset_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU decoder, using the `ALU_*` encodings from ALUop.v.
- Logical, arithmetic and compare ops complete in one cycle.
- Shifts use a bit-serial shifter that performs one bit position per cycle, which keeps area low.
- A valid/ready handshake on both the input and output sides lets the pipeline control logic stall execute while a shift is in progress.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, shift-amount width. Must equal log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept a new operation.
- ALUop  input  4  operation code, `ALU_*` encoding.
- A  input  DATA_W  operand A. For shifts, A[SHAMT_W-1:0] is the shift amount.
- B  input  DATA_W  operand B. For shifts, B is the value shifted.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- Out  output  DATA_W  registered result.

Behaviour:
- Reset, applied on any cycle including mid-shift:
  - state=IDLE, in_ready=1, out_valid=0, Out=0, internal counter=0.
  - Any in-flight operation is discarded.
- States are IDLE, SHIFT and DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: occurs on a rising edge with state==IDLE and in_valid=1. ALUop, A and B are captured on that edge and ignored afterwards.
- Single-cycle ops (ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_LUI):
  - Out is written on the accept edge and the state goes to DONE.
  - out_valid is visible 1 cycle after accept.
- Arithmetic and width rules:
  - ADDU/SUBU wrap modulo 2^DATA_W. No overflow flag.
  - SLT: signed compare A<B, result 1 or 0, zero-extended.
  - SLTU: unsigned compare, result 1 or 0, zero-extended.
  - NOR = ~(A|B).
  - LUI = {B[15:0], 16'h0000}.
- Shift ops (ALU_SLL, ALU_SRL, ALU_SRA):
  - On accept: the working register is loaded with B and the counter with n = A[SHAMT_W-1:0]. Upper bits of A are ignored.
  - n==0: Out=B and the state goes directly to DONE, giving 1-cycle latency.
  - n>0: the state goes to SHIFT. Each following cycle shifts the working register by one bit and decrements the counter.
    - SLL fills with 0.
    - SRL fills with 0.
    - SRA replicates the MSB.
  - On the edge where the counter reaches 0, the state goes to DONE and Out takes the final value.
  - Total latency from accept to out_valid is 1+n cycles. The maximum is 32 for n=31.
- Unrecognised ALUop: Out=0, 1-cycle latency. No error flag.
- DONE:
  - Out and out_valid are held stable until out_ready=1.
  - On an edge with out_ready=1 the state goes to IDLE.
  - in_ready is low throughout DONE, so there is no same-cycle accept. Back-to-back issue costs one IDLE cycle.
- Stability: in_valid toggling while in SHIFT or DONE has no effect. Changes to A, B or ALUop after accept have no effect.
- out_ready while not in DONE is ignored.

Test Plan:
- Reset, then ALUop=ALU_ADDU, A=32'hFFFFFFFF, B=32'h2, in_valid pulse -> in_ready drops, out_valid=1 one cycle later, Out=32'h00000001.
- ALU_SLT, A=32'hFFFFFFFE (-2), B=32'h1 -> Out=1. Same operands with ALU_SLTU -> Out=0. ALU_LUI, B=32'h0000ABCD -> Out=32'hABCD0000.
- ALU_SRA, A=32'h00000024 (amount 4), B=32'h80000F00 -> out_valid after exactly 5 cycles, Out=32'hF80000F0, in_ready=0 throughout. Same operands with ALU_SRL -> Out=32'h080000F0.
- ALU_SLL, A=0, B=32'h1234 -> 1-cycle latency, Out=32'h1234. ALU_SLL, A=31, B=1 -> 32-cycle latency, Out=32'h80000000.
- Hold out_ready=0 for 10 cycles after the result of ALU_XOR, A=32'hF0F0F0F0, B=32'hFFFF0000 -> Out=32'h0F0FF0F0 stable, in_ready=0. Raise out_ready -> IDLE next cycle, and a new op is accepted on the following edge.
- Start ALU_SLL with amount 20, assert rst during cycle 6 -> next cycle out_valid=0, Out=0, in_ready=1. A subsequent ALU_OR, A=32'h0F, B=32'hF0 -> Out=32'hFF.
